// File: rtl/el2_lsu_quiesce_ctl.sv
// LSU quiesce controller: blocks new LSU work on a halt request, acknowledges once the
// LSU has been idle long enough, and forces the LSU clocks on for a warm-up window on release.
module el2_lsu_quiesce_ctl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       halt_req,
  input  logic       lsu_p_valid,
  input  logic       lsu_pkt_d_valid,
  input  logic       lsu_pkt_m_valid,
  input  logic       lsu_pkt_r_valid,
  input  logic       dma_dccm_req,
  input  logic       lsu_bus_buffer_empty_any,
  input  logic       lsu_stbuf_empty_any,
  output logic       lsu_block_new,
  output logic       lsu_halt_ack,
  output logic       lsu_clk_force_en,
  output logic       lsu_idle_q,
  output logic [1:0] lsu_qstate
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    WAKE   = 2'd3
  } qstate_e;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

  qstate_e    state_r;
  qstate_e    state_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic       idle_s;

  assign idle_s = ~(lsu_p_valid | lsu_pkt_d_valid | lsu_pkt_m_valid | lsu_pkt_r_valid | dma_dccm_req)
                & lsu_bus_buffer_empty_any & lsu_stbuf_empty_any;

  // Next-state and idle/warm-up counter
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = 8'd0;
    case (state_r)
      RUN: begin
        if (halt_req) state_nxt_s = DRAIN;
        else          state_nxt_s = RUN;
      end
      DRAIN: begin
        // An abandoned request wins even on the cycle the idle count completes
        if (!halt_req)                state_nxt_s = RUN;
        else if (!idle_s)             cnt_nxt_s   = 8'd0;
        else if (cnt_r == IDLE_LAST)  state_nxt_s = HALTED;
        else                          cnt_nxt_s   = cnt_r + 8'd1;
      end
      HALTED: begin
        if (!halt_req)    state_nxt_s = WAKE;
        else if (!idle_s) state_nxt_s = DRAIN;
        else              state_nxt_s = HALTED;
      end
      WAKE: begin
        if (cnt_r == WAKE_LAST) begin
          if (halt_req) state_nxt_s = DRAIN;
          else          state_nxt_s = RUN;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // State registers with outputs registered from the next-state decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= RUN;
      cnt_r            <= 8'd0;
      lsu_idle_q       <= 1'b0;
      lsu_block_new    <= 1'b0;
      lsu_halt_ack     <= 1'b0;
      lsu_clk_force_en <= 1'b0;
      lsu_qstate       <= 2'd0;
    end else begin
      state_r          <= state_nxt_s;
      cnt_r            <= cnt_nxt_s;
      lsu_idle_q       <= idle_s;
      lsu_block_new    <= (state_nxt_s != RUN);
      lsu_halt_ack     <= (state_nxt_s == HALTED);
      lsu_clk_force_en <= (state_nxt_s == WAKE);
      lsu_qstate       <= state_nxt_s;
    end
  end

endmodule
